alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the `alu_op` code produced by the ALU control unit, together with two operands, and returns a registered result plus branch flags.
- Uses a valid/ready handshake on both the input side and the output side.
- ADD, SUB, SLT, SLTU, XOR, OR and AND complete in one cycle.
- SLL, SRL and SRA run on an iterative one-bit-per-cycle shifter. This lets the multi-cycle core stall on shifts instead of paying for a barrel shifter.

Parameters:
- XLEN, 32, operand and result width.
- ALU_OP_W, 4, width of `alu_op`.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- alu_op  input  ALU_OP_W  operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 are reserved
- op_a  input  XLEN  operand A (rs1)
- op_b  input  XLEN  operand B (rs2 or immediate); bits [4:0] are the shift amount
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- result  output  XLEN  operation result
- zero  output  1  result == 0
- busy  output  1  a shift is in progress

Behaviour:
- Reset (clk and rst):
  - rst is synchronous and active-high on clk; it dominates every other input.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, busy=0, shift counter=0.
  - Reset mid-shift abandons the operation; no result is ever presented for it.
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept: a request is accepted when in_valid && in_ready at a clock edge. alu_op, op_a and op_b are captured at that edge; later input changes are ignored.
- Non-shift ops: result is computed from the captured operands and registered at the accept edge, then IDLE -> DONE. out_valid rises the following cycle (latency 1).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; no carry or overflow output.
  - SLT compares signed, SLTU compares unsigned; result is 0 or 1, zero-extended.
  - Reserved alu_op codes yield result=0 and zero=1, with latency 1.
- Shift ops:
  - shamt = op_b[4:0]; op_b[XLEN-1:5] are ignored.
  - shamt=0: handled as a non-shift op, latency 1, result=op_a.
  - shamt>0: working register=op_a, counter=shamt, IDLE -> SHIFT.
  - Each SHIFT cycle shifts by one bit and decrements the counter.
    - SLL shifts in 0 at the LSB.
    - SRL shifts in 0 at the MSB.
    - SRA replicates the sign bit.
  - When the counter reaches 1 and that final shift is performed, SHIFT -> DONE.
  - Total latency from accept to out_valid is shamt+1 cycles (maximum 32).
- DONE:
  - result and zero are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: DONE -> IDLE, out_valid=0, result holds its last value.
  - in_ready returns the cycle after the handshake; there is no accept in the same cycle as the output handshake.
- zero is updated together with result and is valid whenever out_valid=1.
- in_valid is ignored while in_ready=0; requests are not queued.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined:
  - SLL/SRL/SRA use a combinational barrel shifter and complete like non-shift ops, latency 1.
  - The SHIFT state is unreachable and busy stays 0.
- Undefined: the iterative shifter described above is used, latency shamt+1.
- Results are bit-identical in both builds.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1.
  - Required: in_ready=1, out_valid=0, result=0, busy=0; nothing is accepted.
- ADD/SUB:
  - ADD 0xFFFFFFFF + 0x00000001 -> after 1 cycle: result=0x00000000, zero=1.
  - SUB 5-7 -> result=0xFFFFFFFE, zero=0.
- Set-less-than:
  - SLT op_a=0xFFFFFFFF, op_b=0x00000001 -> result=1.
  - SLTU with the same operands -> result=0.
- Arithmetic shift, iterative build:
  - SRA op_a=0x80000000, op_b=0x0000001F -> busy=1 for 31 cycles; out_valid 32 cycles after accept; result=0xFFFFFFFF.
  - SLL op_a=1, op_b=0x00000020 (shamt=0) -> latency 1, result=1.
- Backpressure:
  - Stimulus: XOR 0xF0F0F0F0 ^ 0xFFFF0000 with out_ready=0 for 5 cycles.
  - Required: result stays 0x0F0FF0F0, out_valid stays 1, in_ready stays 0.
  - Then out_ready=1: out_valid drops the next cycle and in_ready=1.
- Reset mid-shift:
  - Stimulus: SRL shamt=20, assert rst at cycle 6.
  - Required: IDLE next cycle, out_valid never asserts; the next AND 0xFF & 0x0F gives result=0x0000000F.

Source files
------------

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU with valid/ready handshakes on both sides. ADD, SUB, SLT,
// SLTU, XOR, OR, AND and zero-distance shifts complete in one cycle. SLL, SRL
// and SRA with a non-zero shift amount run on an iterative one-bit-per-cycle
// shifter, so the core stalls on shifts rather than carrying a barrel shifter.
//
// Build option:
//   ALU_FAST_SHIFT_EN  - when defined, shifts use a combinational barrel
//                        shifter and complete in one cycle; the SHIFT state is
//                        never entered and busy stays 0. Results are identical
//                        in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation request
//   in_ready   unit can accept a request (high only in IDLE)
//   alu_op     0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//              8 OR, 9 AND; 10-15 reserved (result 0)
//   op_a       operand A (rs1)
//   op_b       operand B (rs2 or immediate); bits [4:0] are the shift amount
//   out_valid  result available
//   out_ready  consumer accepts the result
//   result     operation result
//   zero       result == 0, valid whenever out_valid is high
//   busy       an iterative shift is in progress
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     op_a,
  input  logic [XLEN-1:0]     op_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result,
  output logic                zero,
  output logic                busy
);

  localparam int SHAMT_W = 5;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(9);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic              busy_reg;
  logic [XLEN-1:0]   result_reg;
  logic              zero_reg;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_result;

  assign shamt = op_b[SHAMT_W-1:0];

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;

`ifdef ALU_FAST_SHIFT_EN
  // ---------------------------------------------------------------------------
  // Log-structured barrel shifter: stage gi shifts by 2**gi when shamt[gi] set.
  // ---------------------------------------------------------------------------
  logic [SHAMT_W:0][XLEN-1:0] bs_stage;
  logic [XLEN-1:0]            barrel_result;

  assign bs_stage[0]   = op_a;
  assign barrel_result = bs_stage[SHAMT_W];

  genvar gi;
  for (gi = 0; gi < SHAMT_W; gi++) begin : g_barrel
    localparam int DIST = 1 << gi;
    logic [XLEN-1:0] stage_shifted;

    always_comb begin
      stage_shifted = bs_stage[gi];
      case (alu_op)
        OP_SLL:  stage_shifted = bs_stage[gi] << DIST;
        OP_SRL:  stage_shifted = bs_stage[gi] >> DIST;
        OP_SRA:  stage_shifted = $signed(bs_stage[gi]) >>> DIST;
        default: stage_shifted = bs_stage[gi];
      endcase
    end

    assign bs_stage[gi+1] = shamt[gi] ? stage_shifted : bs_stage[gi];
  end
`else
  // ---------------------------------------------------------------------------
  // Iterative shifter state: working value, remaining distance and direction.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]     shift_reg;
  logic [SHAMT_W-1:0]  cnt_reg;
  logic [ALU_OP_W-1:0] shift_op_reg;
  logic [XLEN-1:0]     shift_next;
  logic                is_shift;
  logic                start_iter;

  assign is_shift   = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  // A zero-distance shift is just a copy of op_a and takes the one-cycle path.
  assign start_iter = is_shift && (shamt != '0);

  always_comb begin
    shift_next = shift_reg;
    case (shift_op_reg)
      OP_SLL:  shift_next = {shift_reg[XLEN-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, shift_reg[XLEN-1:1]};
      OP_SRA:  shift_next = {shift_reg[XLEN-1], shift_reg[XLEN-1:1]};
      default: shift_next = shift_reg;
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Single-cycle result, computed straight from the request so it can be
  // registered at the accept edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_AND:  alu_result = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: alu_result = barrel_result;
`else
      // Only reaches the result register when shamt == 0.
      OP_SLL, OP_SRL, OP_SRA: alu_result = op_a;
`endif
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake/status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      shift_reg     <= '0;
      cnt_reg       <= '0;
      shift_op_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_ready_reg <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            if (start_iter) begin
              shift_reg    <= op_a;
              cnt_reg      <= shamt;
              shift_op_reg <= alu_op;
              busy_reg     <= 1'b1;
              state_reg    <= SHIFT;
            end else
`endif
            begin
              result_reg    <= alu_result;
              zero_reg      <= (alu_result == '0);
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end

        SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg - 1'b1;
          // The shift performed with cnt_reg == 1 is the last one.
          if (cnt_reg == SHAMT_W'(1)) begin
            result_reg    <= shift_next;
            zero_reg      <= (shift_next == '0);
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= DONE;
          end
`else
          // Unreachable in this build; fall back to a clean idle.
          busy_reg     <= 1'b0;
          in_ready_reg <= 1'b1;
          state_reg    <= IDLE;
`endif
        end

        DONE: begin
          // in_ready only comes back the cycle after the output handshake.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          lat;
    int          busy_cycles;
  } exp_t;

  exp_t sb_q[$];

  alu_exec_unit #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, push its expectation, then wait for the
  // result, compare against the popped expectation, apply `hold` cycles of
  // backpressure and finish with the output handshake.
  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat,
                       input int exp_busy, input int hold);
    int   lat;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    sb_q.push_back('{exp_res, (exp_res == 32'd0), exp_lat, exp_busy});
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs: the unit must have captured them at the accept edge.
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    lat      = 1;
    busy_cnt = 0;
    seen     = 0;
    while (!seen && lat <= 40) begin
      if (out_valid) begin
        seen = 1;
      end else begin
        if (busy) busy_cnt++;
        lat++;
        @(negedge clk);
      end
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (seen) begin
      e = sb_q.pop_front();
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy_cycles));
      check({tag, "_result"}, result, e.res);
      check({tag, "_zero"}, 32'(zero), 32'(e.zero));
      for (int i = 0; i < hold; i++) begin
        // A new request during backpressure must be ignored.
        in_valid = 1'b1;
        alu_op   = 4'd0;
        op_a     = $urandom;
        op_b     = $urandom;
        @(negedge clk);
        check({tag, "_hold_result"}, result, e.res);
        check({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_post_result"}, result, e.res);
    end
  endtask

  initial begin
    int vcount;

    // Reset held for 2 cycles with a request pending.
    rst      = 1'b1;
    in_valid = 1'b1;
    alu_op   = 4'd0;
    op_a     = 32'h1234_5678;
    op_b     = 32'h1111_1111;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", 32'(zero), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_nothing_accepted", 32'(out_valid), 32'd0);

    do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0);
    do_op("sub",      4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0, 0);
    do_op("slt",      4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1, 0, 0);
    do_op("sltu",     4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1, 0, 0);
    do_op("sra31",    4'd7, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32, 31, 0);
    do_op("sll_sh0",  4'd2, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1, 0, 0);
    do_op("xor_bp",   4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1, 0, 5);
    do_op("reserved", 4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1, 0, 0);
    do_op("sll4",     4'd2, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 5, 4, 0);
    do_op("srl8",     4'd6, 32'hF000_0000, 32'h0000_0008, 32'h00F0_0000, 9, 8, 0);
    do_op("sra4_pos", 4'd7, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000, 5, 4, 0);
    do_op("or",       4'd8, 32'hA000_0005, 32'h0500_000A, 32'hA500_000F, 1, 0, 0);

    // Reset in the middle of an SRL by 20: no result may ever appear.
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_op   = 4'd6;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_idle_in_ready", 32'(in_ready), 32'd1);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_idle_out_valid", 32'(out_valid), 32'd0);
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("midrst_no_output", 32'(vcount), 32'd0);

    do_op("and_after_rst", 4'd9, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1, 0, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
